// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external 64-bit ALU between two requesters.
// One op per 3 cycles at best: grant (IDLE), capture (EXEC), hold until rsp handshake (RESP).
module alu_share_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q;
  logic        ptr_q;
  logic        id_q;
  logic [63:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_err_q;
  logic [63:0] rsp_result_q;

  logic        gnt_vld, gnt_id, op_legal;
  logic [63:0] result_d;
  logic        zero_d;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt_vld    = !reset && (state_q == IDLE) && (req0_valid || req1_valid);
    gnt_id     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    req0_ready = gnt_vld && !gnt_id;
    req1_ready = gnt_vld && gnt_id;
  end

  always_comb begin
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
    result_d = op_legal ? alu_result : 64'd0;
    zero_d   = op_legal ? alu_zero   : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            a_q     <= gnt_id ? req1_a  : req0_a;
            b_q     <= gnt_id ? req1_b  : req0_b;
            op_q    <= gnt_id ? req1_op : req0_op;
            id_q    <= gnt_id;
            ptr_q   <= !gnt_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= id_q;
          rsp_result_q <= result_d;
          rsp_zero_q   <= zero_d;
          rsp_err_q    <= !op_legal;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [63:0] rsp_result;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Shared ALU; illegal codes return garbage the arbiter must ignore.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      4'b1000: alu_result = alu_a << alu_b[5:0];
      default: alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    endcase
    alu_zero = (alu_result == 64'd0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b, res;
    logic        zero;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0};
    tbl[1] = '{4'b1100, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[2] = '{4'b1000, 64'h1, 64'h4, 64'h10, 1'b0};
    tbl[3] = '{4'b0001, 64'h0, 64'h0, 64'h0, 1'b1};

    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    step(); step();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);

    // Single ADD on requester 0
    req1_valid = 1'b0;
    req0_a = 64'd5; req0_b = 64'd7; req0_op = 4'b0010; rsp_ready = 1'b1;
    reset = 1'b0; #1;
    chk("add_rdy0", req0_ready, 1);
    chk("add_rdy1", req1_ready, 0);
    step(); req0_valid = 1'b0; #1;
    chk("add_exec_rdy0", req0_ready, 0);
    chk("add_alu_a", alu_a, 5);
    chk("add_exec_vld", rsp_valid, 0);
    step();
    chk("add_vld", rsp_valid, 1);
    chk("add_id", rsp_id, 0);
    chk("add_res", rsp_result, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_err", rsp_err, 0);
    step();
    chk("add_done", rsp_valid, 0);

    // Contention after a fresh reset: grants alternate starting at 0
    reset = 1'b1; step(); reset = 1'b0;
    req0_a = 64'd1;  req0_b = 64'd2;  req0_op = 4'b0010;
    req1_a = 64'd10; req1_b = 64'd20; req1_op = 4'b0001;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("cont_rdy0", req0_ready, (i % 2) == 0);
      chk("cont_rdy1", req1_ready, (i % 2) == 1);
      step();
      chk("cont_exec_rdy", {req0_ready, req1_ready}, 0);
      step();
      chk("cont_id", rsp_id, i % 2);
      chk("cont_res", rsp_result, (i % 2) ? 64'd30 : 64'd3);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure with SUB 9-9; req1 waits meanwhile
    req0_a = 64'd9; req0_b = 64'd9; req0_op = 4'b0110; req0_valid = 1'b1;
    rsp_ready = 1'b0; #1;
    chk("bp_rdy0", req0_ready, 1);
    step(); req0_valid = 1'b0;
    req1_a = 64'd1; req1_b = 64'd1; req1_op = 4'b0011; req1_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", rsp_valid, 1);
      chk("bp_res", rsp_result, 0);
      chk("bp_zero", rsp_zero, 1);
      chk("bp_rdy1", req1_ready, 0);
      step();
    end
    rsp_ready = 1'b1; #1;
    chk("bp_hs_rdy1", req1_ready, 0);
    step();
    chk("bp_released", rsp_valid, 0);
    chk("ill_rdy1", req1_ready, 1);

    // Illegal opcode from requester 1
    step(); req1_valid = 1'b0;
    step();
    chk("ill_vld", rsp_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_res", rsp_result, 0);
    chk("ill_zero", rsp_zero, 1);
    chk("ill_id", rsp_id, 1);
    step();

    // Remaining legal opcodes via lone requester 0
    foreach (tbl[k]) begin
      req0_a = tbl[k].a; req0_b = tbl[k].b; req0_op = tbl[k].op; req0_valid = 1'b1; #1;
      chk("tbl_rdy0", req0_ready, 1);
      step(); req0_valid = 1'b0;
      step();
      chk("tbl_res", rsp_result, tbl[k].res);
      chk("tbl_zero", rsp_zero, tbl[k].zero);
      chk("tbl_err", rsp_err, 0);
      step();
    end

    // Reset in EXEC: pointer left favouring 1, reset must restore 0
    req0_a = 64'd4; req0_b = 64'd4; req0_op = 4'b0010; req0_valid = 1'b1;
    step(); req0_valid = 1'b0; reset = 1'b1;
    req1_valid = 1'b1; #1;
    chk("rst_mid_rdy1", req1_ready, 0);
    step(); reset = 1'b0; req1_valid = 1'b0; #1;
    chk("rst_mid_vld", rsp_valid, 0);
    chk("rst_mid_alu_a", alu_a, 0);
    chk("rst_mid_res", rsp_result, 0);
    step();
    chk("rst_mid_no_rsp", rsp_valid, 0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("rst_mid_gnt0", req0_ready, 1);
    chk("rst_mid_gnt1", req1_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
